// File: rtl/addr_sreg_counter_if.sv
// Bus bundle between the AVR-facing serial port / bus_fsm and addr_sreg_counter.
// master: the AVR side and bus_fsm, which drive the serial load, the strobe and the hold.
// slave:  the address generator itself.
// Optional macro SREG_READBACK_EN adds avr_so, the old address shifted out during a load.
interface addr_sreg_counter_if #(
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned CNT_W      = 5
);
  // AVR serial load and increment strobe, plus the bus_fsm hold request
  logic                  avr_si;
  logic                  avr_sreg_en;
  logic                  avr_counter;
  logic                  addr_hold;

  // Address and status back towards the SRAM pins / AVR
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic                  addr_valid;
  logic                  addr_wrap;
  logic                  load_err;
  logic                  inc_overrun;
  logic [CNT_W-1:0]      bit_cnt;
`ifdef SREG_READBACK_EN
  logic                  avr_so;
`endif

  modport master (
`ifdef SREG_READBACK_EN
    input  avr_so,
`endif
    output avr_si,
    output avr_sreg_en,
    output avr_counter,
    output addr_hold,
    input  sram_addr,
    input  addr_valid,
    input  addr_wrap,
    input  load_err,
    input  inc_overrun,
    input  bit_cnt
  );

  modport slave (
`ifdef SREG_READBACK_EN
    output avr_so,
`endif
    input  avr_si,
    input  avr_sreg_en,
    input  avr_counter,
    input  addr_hold,
    output sram_addr,
    output addr_valid,
    output addr_wrap,
    output load_err,
    output inc_overrun,
    output bit_cnt
  );
endinterface

// File: rtl/addr_sreg_counter.sv
// AVR-facing SRAM address generator. A 21-bit address is shifted in MSB first while
// avr_sreg_en is low and committed to sram_addr one clock after en rises. Falling edges of
// avr_counter then step the address; bus_fsm can defer a step with addr_hold.
// Optional macro SREG_READBACK_EN: adds avr_so, which shifts the previous address out
// MSB first while the new one is shifted in.
module addr_sreg_counter #(
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned CNT_W      = 5
) (
  input logic                avr_clk,
  input logic                avr_reset,
  addr_sreg_counter_if.slave bus
);

  // IDLE: en high. SHIFT: en low. COMMIT: the cycle after en went back high.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

  localparam logic [CNT_W-1:0]      CntFull = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0]      CntSat  = CNT_W'(ADDR_WIDTH + 1);
  localparam logic [CNT_W-1:0]      CntOne  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  state_e                state;
  logic [ADDR_WIDTH-1:0] shift_buf;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  valid;
  logic                  wrap;
  logic                  err;
  logic                  overrun;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_prev;
  logic                  pending;

  logic                  shift_entry;
  logic                  shifting;
  logic                  commit;
  logic                  strobe_edge;
  logic                  strobe_ok;
  logic                  inc_now;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  addr_max;
  logic [CNT_W-1:0]      cnt_next;

  // Edge decode and increment arbitration; commit always beats an increment.
  always_comb begin
    shifting    = !bus.avr_sreg_en;
    shift_entry = shifting && (state != StShift);
    commit      = (state == StCommit);
    strobe_edge = cnt_prev && !bus.avr_counter;
    // Strobes count only while idle: not while shifting, not on the en rising edge.
    strobe_ok   = strobe_edge && bus.avr_sreg_en && (state != StShift);
    inc_now     = !commit && !bus.addr_hold && (pending || strobe_ok);
    addr_inc    = addr + AddrOne;
    addr_max    = &addr;
    cnt_next    = (cnt == CntSat) ? CntSat : cnt + CntOne;
  end

  // Control FSM, shift buffer, address counter and status flags.
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      state     <= StIdle;
      shift_buf <= '0;
      addr      <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      cnt       <= '0;
      cnt_prev  <= 1'b1;
      pending   <= 1'b0;
    end else begin
      cnt_prev <= bus.avr_counter;

      unique case (state)
        StIdle:   state <= shifting ? StShift : StIdle;
        StShift:  state <= shifting ? StShift : StCommit;
        StCommit: state <= shifting ? StShift : StIdle;
        default:  state <= StIdle;
      endcase

      // Entry restarts the buffer so short loads zero-extend; surplus bits fall off the top.
      if (shifting) begin
        if (shift_entry) begin
          shift_buf <= {{(ADDR_WIDTH - 1){1'b0}}, bus.avr_si};
          cnt       <= CntOne;
        end else begin
          shift_buf <= {shift_buf[ADDR_WIDTH-2:0], bus.avr_si};
          cnt       <= cnt_next;
        end
      end

      if (commit) begin
        addr    <= shift_buf;
        valid   <= 1'b1;
        err     <= (cnt != CntFull);
        wrap    <= 1'b0;
        overrun <= 1'b0;
        pending <= 1'b0;
      end else begin
        if (inc_now) begin
          addr <= addr_inc;
          if (addr_max) begin
            wrap <= 1'b1;
          end
        end
        // A strobe on top of an outstanding one is flagged and dropped.
        if (pending && strobe_ok) begin
          overrun <= 1'b1;
        end
        if (inc_now) begin
          pending <= 1'b0;
        end else if (strobe_ok) begin
          pending <= 1'b1;
        end
      end
    end
  end

`ifdef SREG_READBACK_EN
  logic [ADDR_WIDTH-1:0] rb_buf;
  logic                  so;

  // Readback: capture the live address on shift entry and stream it out MSB first.
  always_ff @(posedge avr_clk) begin
    if (avr_reset) begin
      rb_buf <= '0;
      so     <= 1'b0;
    end else if (shifting) begin
      if (shift_entry) begin
        so     <= addr[ADDR_WIDTH-1];
        rb_buf <= {addr[ADDR_WIDTH-2:0], 1'b0};
      end else begin
        so     <= rb_buf[ADDR_WIDTH-1];
        rb_buf <= {rb_buf[ADDR_WIDTH-2:0], 1'b0};
      end
    end else begin
      so <= 1'b0;
    end
  end

  assign bus.avr_so = so;
`endif

  assign bus.sram_addr   = addr;
  assign bus.addr_valid  = valid;
  assign bus.addr_wrap   = wrap;
  assign bus.load_err    = err;
  assign bus.inc_overrun = overrun;
  assign bus.bit_cnt     = cnt;

endmodule

// File: tb/tb_addr_sreg_counter.sv
// Scoreboard bench for addr_sreg_counter: each operation updates a small behavioural model,
// pushes the expected output state, and the state is popped and compared once the DUT
// has had its clock. Inputs change on the falling edge, outputs are sampled there too.
module tb_addr_sreg_counter;

  localparam int unsigned AW = 21;
  localparam int unsigned CW = 5;

  typedef struct {
    string         tag;
    logic [AW-1:0] addr;
    logic          valid;
    logic          wrap;
    logic          err;
    logic          ovr;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst;

  addr_sreg_counter_if #(.ADDR_WIDTH(AW), .CNT_W(CW)) bus ();

  addr_sreg_counter #(.ADDR_WIDTH(AW), .CNT_W(CW)) dut (
    .avr_clk   (clk),
    .avr_reset (rst),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];
  logic so_q[$];

  // Behavioural model of the spec
  logic [AW-1:0] m_addr;
  logic          m_valid, m_wrap, m_err, m_ovr, m_pend;
  logic [CW-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_addr = '0; m_valid = 0; m_wrap = 0; m_err = 0; m_ovr = 0; m_pend = 0; m_cnt = '0;
  endtask

  task automatic model_inc();
    if (m_addr == {AW{1'b1}}) m_wrap = 1'b1;
    m_addr = m_addr + 1'b1;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag; e.addr = m_addr; e.valid = m_valid; e.wrap = m_wrap;
    e.err = m_err; e.ovr = m_ovr; e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".addr"},  32'(bus.sram_addr),   32'(e.addr));
    check({e.tag, ".valid"}, 32'(bus.addr_valid),  32'(e.valid));
    check({e.tag, ".wrap"},  32'(bus.addr_wrap),   32'(e.wrap));
    check({e.tag, ".err"},   32'(bus.load_err),    32'(e.err));
    check({e.tag, ".ovr"},   32'(bus.inc_overrun), 32'(e.ovr));
    check({e.tag, ".cnt"},   32'(bus.bit_cnt),     32'(e.cnt));
  endtask

  task automatic check_so(input string tag);
`ifdef SREG_READBACK_EN
    check(tag, 32'(bus.avr_so), 32'(so_q.pop_front()));
`else
    void'(so_q.pop_front());
`endif
  endtask

  // Shift nbits of value MSB first, optionally pulsing the strobe at bit strobe_at, then commit.
  task automatic do_load(input logic [31:0] value, input int nbits, input int strobe_at,
                         input string tag);
    logic [AW-1:0] old;
    old = m_addr;
    for (int i = 0; i < nbits; i++) begin
      bus.avr_sreg_en = 1'b0;
      bus.avr_si      = value[nbits-1-i];
      bus.avr_counter = (i == strobe_at) ? 1'b0 : 1'b1;
      so_q.push_back((i < int'(AW)) ? old[int'(AW)-1-i] : 1'b0);
      tick();
      check_so({tag, ".so"});
    end
    bus.avr_sreg_en = 1'b1;
    bus.avr_counter = 1'b1;
    tick();
    m_addr = value[AW-1:0]; m_valid = 1'b1; m_wrap = 1'b0; m_ovr = 1'b0; m_pend = 1'b0;
    m_err  = (nbits != int'(AW));
    m_cnt  = (nbits > int'(AW)) ? CW'(AW + 1) : CW'(nbits);
    push_exp(tag);
    tick();
    compare();
  endtask

  task automatic do_strobe(input logic hold, input string tag);
    bus.addr_hold   = hold;
    bus.avr_counter = 1'b0;
    if (m_pend) begin
      m_ovr = 1'b1;
      if (!hold) begin model_inc(); m_pend = 1'b0; end
    end else if (!hold) model_inc();
    else m_pend = 1'b1;
    push_exp(tag);
    tick();
    compare();
    bus.avr_counter = 1'b1;
    tick();
  endtask

  task automatic release_hold(input string tag);
    bus.addr_hold = 1'b0;
    if (m_pend) begin model_inc(); m_pend = 1'b0; end
    push_exp(tag);
    tick();
    compare();
  endtask

  initial begin
    rst = 1'b1;
    bus.avr_si = 1'b0; bus.avr_sreg_en = 1'b1; bus.avr_counter = 1'b1; bus.addr_hold = 1'b0;
    model_clear();
    push_exp("reset");
    tick(); tick();
    compare();
    rst = 1'b0;
    tick();

    do_load(32'h0ABCDE, 21, -1, "load_abcde");
    do_strobe(1'b0, "inc_abcdf");

    do_load(32'h1FFFFF, 21, -1, "load_max");
    do_strobe(1'b0, "wrap");
    do_load(32'h000010, 21, -1, "load_10");

    do_strobe(1'b1, "hold_strobe1");
    do_strobe(1'b1, "hold_strobe2");
    release_hold("hold_release");
    release_hold("hold_idle");

    do_load(32'h00BEEF, 16, -1, "short_load");
    do_load(32'h723456, 23, -1, "long_load");

    do_load(32'h0ABCDE, 21, 5, "strobe_in_shift");
    release_hold("no_pending");
    do_load(32'h000001, 21, -1, "readback_load");

    // Reset in the middle of a shift with an increment pending
    do_strobe(1'b1, "pend_before_rst");
    for (int i = 0; i < 10; i++) begin
      bus.avr_sreg_en = 1'b0;
      bus.avr_si      = 1'b1;
      tick();
    end
    rst = 1'b1;
    model_clear();
    push_exp("mid_shift_reset");
    so_q.push_back(1'b0);
    tick();
    compare();
    check_so("rst.so");
    rst = 1'b0;
    bus.avr_sreg_en = 1'b1;
    release_hold("after_reset_hold");
    do_strobe(1'b0, "inc_before_commit");
    do_load(32'h000005, 21, -1, "load_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
